// File: rtl/branch_resolve.sv
// Branch resolution unit for the multicycle core.
// Samples one-hot branch strobes and operands on start, evaluates the condition and
// target one cycle later, then presents a one-cycle done / pc_write response.
// Also keeps counters of legal resolved branches and of branches that wrote the PC.
module branch_resolve #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             beq,
    input  logic             bne,
    input  logic             blt,
    input  logic             bge,
    input  logic             bltu,
    input  logic             bgeu,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             clr_cnt,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             pc_write,
    output logic [XLEN-1:0]  target,
    output logic             illegal,
    output logic             misaligned,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

    state_e            state_q, state_d;
    // Latched strobes, bit order {bgeu, bltu, bge, blt, bne, beq}
    logic [5:0]        strb_q, strb_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;

    logic              done_q, done_d;
    logic              taken_q, taken_d;
    logic              pc_write_q, pc_write_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              illegal_q, illegal_d;
    logic              misaligned_q, misaligned_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

    // Evaluation datapath, only consumed in StEval
    logic              ev_legal;
    logic              ev_cond;
    logic              ev_taken;
    logic              ev_mis;
    logic [XLEN-1:0]   ev_target;

    // Condition, legality and target from the latched values
    always_comb begin
        ev_legal  = ($countones(strb_q) == 1);
        ev_cond   = (strb_q[0] & (rs1_q == rs2_q))
                  | (strb_q[1] & (rs1_q != rs2_q))
                  | (strb_q[2] & ($signed(rs1_q) <  $signed(rs2_q)))
                  | (strb_q[3] & ($signed(rs1_q) >= $signed(rs2_q)))
                  | (strb_q[4] & (rs1_q <  rs2_q))
                  | (strb_q[5] & (rs1_q >= rs2_q));
        ev_taken  = ev_cond & ev_legal;
        ev_target = pc_q + imm_q;
        ev_mis    = ev_taken & (ev_target[1:0] != 2'b00);
    end

    // Next state, operand capture and registered response
    always_comb begin
        state_d      = state_q;
        strb_d       = strb_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        done_d       = 1'b0;
        pc_write_d   = 1'b0;
        taken_d      = taken_q;
        target_d     = target_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    strb_d  = {bgeu, bltu, bge, blt, bne, beq};
                    rs1_d   = rs1_val;
                    rs2_d   = rs2_val;
                    pc_d    = pc;
                    imm_d   = imm;
                    state_d = StEval;
                end
            end
            StEval: begin
                done_d       = 1'b1;
                taken_d      = ev_taken;
                target_d     = ev_target;
                illegal_d    = ~ev_legal;
                misaligned_d = ev_mis;
                pc_write_d   = ev_taken & ~ev_mis;
                state_d      = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Performance counters: bump on the response cycle, clear has priority
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (state_q == StResp) begin
            if (!illegal_q) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (pc_write_q) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
        if (clr_cnt) begin
            branch_cnt_d = '0;
            taken_cnt_d  = '0;
        end
    end

    // State registers with synchronous reset; reset aborts any branch in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            strb_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            done_q       <= 1'b0;
            taken_q      <= 1'b0;
            pc_write_q   <= 1'b0;
            target_q     <= '0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            strb_q       <= strb_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            done_q       <= done_d;
            taken_q      <= taken_d;
            pc_write_q   <= pc_write_d;
            target_q     <= target_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign taken      = taken_q;
    assign pc_write   = pc_write_q;
    assign target     = target_q;
    assign illegal    = illegal_q;
    assign misaligned = misaligned_q;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule
